i2c_target: RTL and testbench

I2C target (slave) responder for the I2C bus, modelling the MPU/BME-style sensor register file that the team's I2C master addresses. It decodes START/STOP, matches a 7-bit device address, loads a register pointer, and then either accepts write bytes or returns read bytes with auto-increment. Its purpose is to be the bus partner for the master in simulation and on the Arty A7 loopback build. SCL and SDA are sampled in the system clock domain; SDA is driven open-drain.

---
 rtl/i2c_target.sv | 237 +++++++++++++++++++++++
 tb/tb_i2c_target.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target with a small register file, pointer auto-increment and open-drain SDA drive.
// Optional 3-sample input glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h76,
  parameter logic [7:0]  REG_BASE = 8'hD0,
  parameter int unsigned NUM_REGS = 32,
  parameter logic [7:0]  CHIP_ID  = 8'h60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  localparam int unsigned IdxW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0]  RegLast = 8'(REG_BASE + NUM_REGS - 1);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWrData, StWrAck, StRdData, StRdAck, StWait
  } state_e;

  // Synchronizers idle high so reset never fakes a bus event.
  logic r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
    end else begin
      r_scl_s1 <= scl_in;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
    end
  end

  logic w_scl, w_sda;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] r_scl_hist, r_sda_hist;
  logic       r_scl_flt, r_sda_flt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_hist <= 2'b11;
      r_sda_hist <= 2'b11;
      r_scl_flt  <= 1'b1;
      r_sda_flt  <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_s2};
      r_sda_hist <= {r_sda_hist[0], r_sda_s2};
      if (&{r_scl_hist, r_scl_s2}) r_scl_flt <= 1'b1;
      else if (~|{r_scl_hist, r_scl_s2}) r_scl_flt <= 1'b0;
      if (&{r_sda_hist, r_sda_s2}) r_sda_flt <= 1'b1;
      else if (~|{r_sda_hist, r_sda_s2}) r_sda_flt <= 1'b0;
    end
  end

  assign w_scl = r_scl_flt;
  assign w_sda = r_sda_flt;
`else
  assign w_scl = r_scl_s2;
  assign w_sda = r_sda_s2;
`endif

  logic r_scl_d, r_sda_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;

  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // SCL must be high in both samples, so a coincident SCL/SDA edge counts as a data bit.
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  state_e            r_state;
  logic [3:0]        r_cnt;
  logic [7:0]        r_shift;
  logic [7:0]        r_ptr;
  logic [7:0]        r_regs [NUM_REGS];
  logic              r_sda_oe;
  logic              r_busy;
  logic              r_wr_strobe;
  logic [7:0]        r_wr_addr;
  logic [7:0]        r_wr_data;

  logic [7:0]        w_byte;
  logic [7:0]        w_ptr_next;
  logic [IdxW-1:0]   w_idx;
  logic [7:0]        w_rd_val;
  logic              w_in_win;

  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_ptr_next = (r_ptr == RegLast) ? REG_BASE : r_ptr + 8'd1;
  assign w_idx      = IdxW'(r_ptr - REG_BASE);
  assign w_rd_val   = r_regs[w_idx];
  assign w_in_win   = (w_byte >= REG_BASE) && (w_byte <= RegLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= 4'd0;
      r_shift     <= 8'h00;
      r_ptr       <= REG_BASE;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 8'h00;
      r_wr_data   <= 8'h00;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= (i == 0) ? CHIP_ID : 8'h00;
      end
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_stop) begin
        r_state  <= StIdle;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_start) begin
        r_state  <= StAddr;
        r_cnt    <= 4'd0;
        r_sda_oe <= 1'b0;
      end else begin
        unique case (r_state)
          StAddr: begin
            if (w_scl_rise) begin
              r_shift <= w_byte;
              r_cnt   <= r_cnt + 4'd1;
              if (r_cnt == 4'd7) begin
                if (w_byte[7:1] == DEV_ADDR) begin
                  r_state <= StAddrAck;
                  r_busy  <= 1'b1;
                end else begin
                  r_state <= StWait;
                end
              end
            end
          end
          // First SCL fall opens the ACK slot, the second one closes it.
          StAddrAck, StPtrAck, StWrAck: begin
            if (w_scl_fall) begin
              if (!r_sda_oe) begin
                r_sda_oe <= 1'b1;
              end else if (r_state == StAddrAck && r_shift[0]) begin
                r_state  <= StRdData;
                r_sda_oe <= ~w_rd_val[7];
                r_shift  <= {w_rd_val[6:0], 1'b0};
                r_cnt    <= 4'd1;
              end else begin
                r_sda_oe <= 1'b0;
                r_cnt    <= 4'd0;
                r_state  <= (r_state == StAddrAck) ? StPtr : StWrData;
              end
            end
          end
          StPtr: begin
            if (w_scl_rise) begin
              r_shift <= w_byte;
              r_cnt   <= r_cnt + 4'd1;
              if (r_cnt == 4'd7) begin
                if (w_in_win) begin
                  r_ptr   <= w_byte;
                  r_state <= StPtrAck;
                end else begin
                  r_state <= StWait;
                end
              end
            end
          end
          StWrData: begin
            if (w_scl_rise) begin
              r_shift <= w_byte;
              r_cnt   <= r_cnt + 4'd1;
              if (r_cnt == 4'd7) begin
                r_wr_strobe <= 1'b1;
                r_wr_addr   <= r_ptr;
                r_wr_data   <= w_byte;
                if (w_idx != '0) r_regs[w_idx] <= w_byte;
                r_ptr       <= w_ptr_next;
                r_state     <= StWrAck;
              end
            end
          end
          StRdData: begin
            if (w_scl_fall) begin
              if (r_cnt == 4'd8) begin
                r_sda_oe <= 1'b0;
                r_ptr    <= w_ptr_next;
                r_state  <= StRdAck;
              end else begin
                r_sda_oe <= ~r_shift[7];
                r_shift  <= {r_shift[6:0], 1'b0};
                r_cnt    <= r_cnt + 4'd1;
              end
            end
          end
          StRdAck: begin
            if (w_scl_rise && w_sda) begin
              r_state <= StWait;
            end else if (w_scl_fall) begin
              r_state  <= StRdData;
              r_sda_oe <= ~w_rd_val[7];
              r_shift  <= {w_rd_val[6:0], 1'b0};
              r_cnt    <= 4'd1;
            end
          end
          StIdle, StWait: ;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign busy      = r_busy;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: drives the bus as a master and checks against a transaction-level model.
module tb_i2c_target;

  localparam logic [6:0]  Dev   = 7'h76;
  localparam logic [7:0]  Base  = 8'hD0;
  localparam int unsigned NRegs = 32;
  localparam logic [7:0]  Last  = 8'(Base + NRegs - 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       sda_oe, busy, wr_strobe;
  logic [7:0] wr_addr, wr_data;

  assign sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  // Transaction-level model: what the target must do per byte, not how.
  typedef enum {MIdle, MAddr, MPtr, MWrite, MRead, MWait} mphase_e;
  mphase_e     m_phase;
  logic [7:0]  m_regs [256];
  logic [7:0]  m_ptr;
  logic        m_busy;
  logic [15:0] exp_q [$];

  function automatic logic [7:0] m_next(input logic [7:0] p);
    return (p == Last) ? Base : p + 8'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_regs[i] = 8'h00;
    m_regs[Base] = 8'h60;
    m_ptr   = Base;
    m_busy  = 1'b0;
    m_phase = MIdle;
  endtask

  logic        exp_valid = 1'b0;
  logic        exp_oe    = 1'b0;
  logic        bchk      = 1'b0;
  logic        exp_busy  = 1'b0;
  logic [15:0] e;

  always @(negedge clk) begin
    if (exp_valid) check1("sda_oe during SCL high", sda_oe, exp_oe);
    if (bchk) check1("busy", busy, exp_busy);
    if (wr_strobe) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wr_strobe: got unexpected write 0x%02h=0x%02h, expected none",
                 wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check8("wr_addr", wr_addr, e[15:8]);
        check8("wr_data", wr_data, e[7:0]);
      end
    end
  end

  // Entered with SCL low (or idle bus); leaves SCL low.
  task automatic bit_slot(input logic b, input logic oe_exp, input logic busy_chk,
                          output logic seen);
    #50 m_sda = b;
    #50 scl = 1'b1;
    exp_oe    = oe_exp;
    exp_busy  = m_busy;
    exp_valid = 1'b1;
    bchk      = busy_chk;
    #50 seen = sda_bus;
    #50 exp_valid = 1'b0;
    bchk = 1'b0;
    scl  = 1'b0;
  endtask

  task automatic bus_start();
    #50 m_sda = 1'b1;
    #50 scl = 1'b1;
    #50 m_sda = 1'b0;
    #50 scl = 1'b0;
    m_phase = MAddr;
  endtask

  task automatic bus_stop();
    #50 m_sda = 1'b0;
    #50 scl = 1'b1;
    #50 m_sda = 1'b1;
    #50;
    m_phase = MIdle;
    m_busy  = 1'b0;
    check1("busy after STOP", busy, 1'b0);
    check1("sda_oe after STOP", sda_oe, 1'b0);
  endtask

  task automatic wr_byte(input logic [7:0] b);
    logic ack, seen, chk;
    chk = (m_phase != MAddr);
    ack = 1'b0;
    case (m_phase)
      MAddr: begin
        if (b[7:1] == Dev) begin
          ack     = 1'b1;
          m_busy  = 1'b1;
          m_phase = b[0] ? MRead : MPtr;
        end else begin
          m_phase = MWait;
        end
      end
      MPtr: begin
        if (b >= Base && b <= Last) begin
          ack     = 1'b1;
          m_ptr   = b;
          m_phase = MWrite;
        end else begin
          m_phase = MWait;
        end
      end
      MWrite: begin
        ack = 1'b1;
        exp_q.push_back({m_ptr, b});
        if (m_ptr != Base) m_regs[m_ptr] = b;
        m_ptr = m_next(m_ptr);
      end
      default: ;
    endcase
    for (int i = 7; i >= 0; i--) bit_slot(b[i], 1'b0, chk, seen);
    bit_slot(1'b1, ack, 1'b1, seen);
    check1($sformatf("ack slot after 0x%02h", b), seen, ~ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] got);
    logic [7:0] exp;
    logic       seen, reading;
    reading = (m_phase == MRead);
    exp = 8'hFF;
    if (reading) begin
      exp   = m_regs[m_ptr];
      m_ptr = m_next(m_ptr);
    end
    for (int i = 7; i >= 0; i--) begin
      bit_slot(1'b1, ~exp[i], 1'b1, seen);
      got[i] = seen;
    end
    check8("read byte vs model", got, exp);
    bit_slot(mack, 1'b0, 1'b1, seen);
    if (reading && mack) m_phase = MWait;
  endtask

  logic [7:0] got;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not reach the summary");
    $fatal(1);
  end

  initial begin
    model_reset();
    @(negedge clk);
    #2;
    #30 rst = 1'b0;
    #20;
    check1("reset sda_oe", sda_oe, 1'b0);
    check1("reset busy", busy, 1'b0);
    check1("reset wr_strobe", wr_strobe, 1'b0);
    check8("reset wr_addr", wr_addr, 8'h00);
    check8("reset wr_data", wr_data, 8'h00);

    // Unmatched device address
    bus_start();
    wr_byte(8'hFC);
    wr_byte(8'h45);
    bus_stop();

    // Out-of-window pointer, then a plain read proves the pointer stayed at 0xD0
    bus_start();
    wr_byte(8'hEC);
    wr_byte(8'h45);
    bus_stop();
    bus_start();
    wr_byte(8'hED);
    rd_byte(1'b1, got);
    check8("pointer kept after NACKed pointer", got, 8'h60);
    bus_stop();

    // Valid write burst and read-back
    bus_start();
    wr_byte(8'hEC);
    wr_byte(8'hE0);
    wr_byte(8'hB6);
    wr_byte(8'h11);
    bus_stop();
    bus_start();
    wr_byte(8'hEC);
    wr_byte(8'hE0);
    bus_start();
    wr_byte(8'hED);
    rd_byte(1'b1, got);
    check8("readback 0xE0", got, 8'hB6);
    bus_stop();

    // CHIP_ID read via repeated START, two bytes
    bus_start();
    wr_byte(8'hEC);
    wr_byte(8'hD0);
    bus_start();
    wr_byte(8'hED);
    rd_byte(1'b0, got);
    check8("CHIP_ID", got, 8'h60);
    rd_byte(1'b1, got);
    check8("reg 0xD1 initial", got, 8'h00);
    bus_stop();

    // Wrap burst over the read-only register
    bus_start();
    wr_byte(8'hEC);
    wr_byte(8'hD1);
    wr_byte(8'h3C);
    bus_stop();
    bus_start();
    wr_byte(8'hEC);
    wr_byte(8'hEF);
    wr_byte(8'hAA);
    wr_byte(8'h55);
    bus_stop();
    bus_start();
    wr_byte(8'hED);
    rd_byte(1'b1, got);
    check8("pointer at 0xD1 after wrap", got, 8'h3C);
    bus_stop();
    bus_start();
    wr_byte(8'hEC);
    wr_byte(8'hEF);
    bus_start();
    wr_byte(8'hED);
    rd_byte(1'b0, got);
    check8("reg 0xEF", got, 8'hAA);
    rd_byte(1'b1, got);
    check8("reg 0xD0 read-only", got, 8'h60);
    bus_stop();

    // Reset while the target pulls SDA for a 0 read bit (reg 0xD1 = 0x3C)
    bus_start();
    wr_byte(8'hED);
    #100 scl = 1'b1;
    #50 check1("driving read bit before rst", sda_oe, 1'b1);
    rst = 1'b1;
    #1 check1("sda_oe released by async rst", sda_oe, 1'b0);
    #29 rst = 1'b0;
    model_reset();
    #20 scl = 1'b0;
    check8("wr_addr after rst", wr_addr, 8'h00);
    check8("wr_data after rst", wr_data, 8'h00);
    bus_stop();
    bus_start();
    wr_byte(8'hED);
    rd_byte(1'b0, got);
    check8("CHIP_ID after rst", got, 8'h60);
    rd_byte(1'b1, got);
    check8("reg 0xD1 cleared by rst", got, 8'h00);
    bus_stop();

    #100;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing wr_strobe: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
